// File: rtl/store_commit_unit.sv
// Store commit unit: takes a committed ROB store and writes it to memory one byte per cycle.
// Optional IO back-pressure is compiled in with `define IO_STALL_EN.
module store_commit_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        commit_en,
  input  logic [1:0]  commit_size,
  input  logic [31:0] commit_addr,
  input  logic [31:0] commit_value,
  output logic        store_success,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] value_q, value_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  idx_q, idx_d;
  logic        armed_q, armed_d;

  logic [31:0] byte_addr;
  logic [31:0] value_shifted;
  logic        io_stall;
  logic        wr_go;

  assign byte_addr     = addr_q + {30'd0, idx_q};
  assign value_shifted = value_q >> {idx_q, 3'b000};

`ifdef IO_STALL_EN
  assign io_stall = (byte_addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  // A byte goes out only when enabled, granted and not held off by the IO buffer.
  assign wr_go = (state_q == S_WRITE) && rdy && mem_grant && !io_stall;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    value_d = value_q;
    last_d  = last_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    if (rdy) begin
      if (!commit_en) armed_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (commit_en && armed_q) begin
            addr_d  = commit_addr;
            value_d = commit_value;
            idx_d   = 2'd0;
            case (commit_size)
              2'b00:   last_d = 2'd0;
              2'b01:   last_d = 2'd1;
              default: last_d = 2'd3;
            endcase
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (mem_grant) state_d = S_WRITE;
        end
        S_WRITE: begin
          if (wr_go) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == last_q) state_d = S_DONE;
          end
        end
        default: begin
          // Disarm so a commit_en still held after success is not taken again.
          armed_d = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      value_q <= 32'd0;
      last_q  <= 2'd0;
      idx_q   <= 2'd0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
    end
  end

  assign mem_wr        = wr_go;
  assign mem_a         = (state_q == S_WRITE) ? byte_addr : 32'd0;
  assign mem_dout      = (state_q == S_WRITE) ? value_shifted[7:0] : 8'd0;
  assign mem_req       = (state_q == S_REQ) || (state_q == S_WRITE);
  assign store_success = (state_q == S_DONE) && rdy;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_store_commit_unit.sv
// Bench for store_commit_unit: table of stores plus hand-written stall, freeze, re-arm and reset sequences.
module tb_store_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        commit_en;
  logic [1:0]  commit_size;
  logic [31:0] commit_addr;
  logic [31:0] commit_value;
  logic        store_success;
  logic        mem_req;
  logic        mem_grant;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  store_commit_unit dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .commit_en     (commit_en),
    .commit_size   (commit_size),
    .commit_addr   (commit_addr),
    .commit_value  (commit_value),
    .store_success (store_success),
    .mem_req       (mem_req),
    .mem_grant     (mem_grant),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  int          num_checks = 0;
  int          num_fail   = 0;
  int          succ_cnt   = 0;
  int          wr_cnt     = 0;
  logic [39:0] exp_q[$];
  logic [39:0] mon_e;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    num_checks++;
    num_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endfunction

  // Scoreboard: every byte strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          num_checks++;
          num_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_a, mem_dout);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mem_write", {24'd0, mem_a, mem_dout}, {24'd0, mon_e});
        end
      end
      if (store_success) succ_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [31:0] addr, input logic [31:0] value, input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = value >> (8 * i);
      exp_q.push_back({addr + 32'(i), v[7:0]});
    end
  endtask

  task automatic start_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] value);
    commit_size  = size;
    commit_addr  = addr;
    commit_value = value;
    commit_en    = 1'b1;
    push_bytes(addr, value, (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4);
  endtask

  // Returns the negedge index (0 = first sample) at which store_success was seen.
  task automatic wait_success(input int max, output int lat);
    bit got;
    got = 0;
    lat = -1;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clk);
      if (store_success) begin
        got = 1;
        lat = k;
      end
    end
    if (!got) fail("success_timeout");
    tick();
  endtask

  task automatic wait_write(input int max);
    bit got;
    got = 0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clk);
      if (mem_wr) got = 1;
    end
    if (!got) fail("write_timeout");
    tick();
  endtask

  task automatic release_commit();
    commit_en = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] value;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, w0, s0, first_wr;

    vecs[0] = '{2'b10, 32'h0000_0100, 32'hAABB_CCDD, 4};
    vecs[1] = '{2'b00, 32'h0000_0007, 32'h1234_5678, 1};
    vecs[2] = '{2'b01, 32'h0000_0003, 32'hCAFE_BEEF, 2};
    vecs[3] = '{2'b11, 32'h0000_1001, 32'h0102_0304, 4};
    vecs[4] = '{2'b10, 32'hFFFF_FFFE, 32'h5566_7788, 4};
    vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_A5A5, 2};

    rst = 1'b1; rdy = 1'b1; commit_en = 1'b0; commit_size = 2'b00;
    commit_addr = 32'd0; commit_value = 32'd0; mem_grant = 1'b0; io_buffer_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_success", store_success, 0);
    tick();

    // Holding off grant keeps the unit parked in REQ.
    start_store(2'b10, 32'h0000_0100, 32'hAABB_CCDD);
    tick(); tick(); tick();
    @(negedge clk);
    chk("req_wait_mem_req", mem_req, 1);
    chk("req_wait_mem_wr", mem_wr, 0);
    chk("req_wait_busy", busy, 1);
    tick();
    mem_grant = 1'b1;
    wait_success(20, lat);
    chk("grant_to_success", lat, 5);
    release_commit();

    foreach (vecs[i]) begin
      w0 = wr_cnt; s0 = succ_cnt;
      start_store(vecs[i].size, vecs[i].addr, vecs[i].value);
      wait_success(20, lat);
      chk("vec_latency", lat, vecs[i].exp_n + 2);
      chk("vec_bytes", wr_cnt - w0, vecs[i].exp_n);
      chk("vec_success_count", succ_cnt - s0, 1);
      release_commit();
    end

    for (int i = 0; i < 4; i++) begin
      start_store(2'($urandom_range(0, 3)), $urandom, $urandom);
      wait_success(20, lat);
      release_commit();
    end
    chk("random_queue_empty", exp_q.size(), 0);

    // Held commit_en after success must not re-trigger until it drops.
    s0 = succ_cnt;
    start_store(2'b00, 32'h0000_0007, 32'h1234_5678);
    wait_success(20, lat);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_no_busy", busy, 0);
      tick();
    end
    chk("held_one_success", succ_cnt - s0, 1);
    commit_en = 1'b0;
    tick();
    commit_en = 1'b1;
    push_bytes(32'h0000_0007, 32'h1234_5678, 1);
    wait_success(20, lat);
    chk("rearm_latency", lat, 3);
    chk("rearm_success_count", succ_cnt - s0, 2);
    release_commit();

    // Grant loss mid-halfword.
    start_store(2'b01, 32'h0000_0200, 32'h0000_7E3C);
    wait_write(20);
    mem_grant = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("nogrant_mem_wr", mem_wr, 0);
      chk("nogrant_mem_req", mem_req, 1);
      tick();
    end
    mem_grant = 1'b1;
    wait_success(20, lat);
    chk("nogrant_resume_latency", lat, 1);
    release_commit();

    // Freeze with rdy low mid-word.
    w0 = wr_cnt;
    start_store(2'b10, 32'h0000_0400, 32'h8899_0011);
    wait_write(20);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("freeze_mem_wr", mem_wr, 0);
      chk("freeze_success", store_success, 0);
      tick();
    end
    rdy = 1'b1;
    wait_success(20, lat);
    chk("freeze_resume_latency", lat, 3);
    chk("freeze_total_bytes", wr_cnt - w0, 4);
    release_commit();

    // IO space byte store with the IO buffer full for 5 cycles.
    io_buffer_full = 1'b1;
    start_store(2'b00, 32'h0003_0000, 32'h0000_009A);
    first_wr = -1; lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_wr && first_wr < 0) first_wr = k;
      if (store_success) lat = k;
      tick();
      if (k == 4) io_buffer_full = 1'b0;
    end
    io_buffer_full = 1'b0;
`ifdef IO_STALL_EN
    chk("io_first_write", first_wr, 5);
    chk("io_success", lat, 6);
`else
    chk("io_first_write", first_wr, 2);
    chk("io_success", lat, 3);
`endif
    release_commit();

    // Reset during the second byte of a word abandons the store.
    s0 = succ_cnt;
    commit_size = 2'b10; commit_addr = 32'h0000_0500; commit_value = 32'h4433_2211;
    commit_en = 1'b1;
    push_bytes(32'h0000_0500, 32'h4433_2211, 1);
    wait_write(20);
    rst = 1'b1;
    commit_en = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_mem_wr", mem_wr, 0);
    chk("rstmid_mem_a", mem_a, 0);
    chk("rstmid_mem_dout", mem_dout, 0);
    tick(); tick(); tick();
    chk("rstmid_no_success", succ_cnt - s0, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
